// File: rtl/zoom_stream_pkg.sv
// zoom_stream shared types: FSM state, zoom level type and crop-origin helpers.
// Used by zoom_stream and its frame RAM; optional pan feature is ZOOM_PAN_EN.
package zoom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // Internal zoom level is wide enough for any sane MAX_ZOOM_LOG2.
    localparam int ZLVL_W = 4;
    typedef logic [ZLVL_W-1:0] zlvl_t;

    // Top-left of a centred crop of size dim>>lvl.
    function automatic int crop_origin(input int dim, input int lvl);
        return dim / 2 - (dim >> (lvl + 1));
    endfunction

    // Keeps a (panned) origin inside the image for the given zoom.
    function automatic int crop_clamp(input int org, input int dim,
                                      input int lvl);
        int hi;
        hi = dim - (dim >> lvl);
        if (org < 0)
            return 0;
        else if (org > hi)
            return hi;
        else
            return org;
    endfunction

endpackage

// File: rtl/zoom_stream_frame_ram.sv
// zoom_frame_ram: simple dual-port frame store, one write and one
// registered read port. Ports: clk, i_we/i_waddr/i_wdata, i_re/i_raddr, o_rdata.
module zoom_frame_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 640 * 480,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/zoom_stream.sv
// zoom_stream: captures one frame, then streams a nearest-neighbour zoom of a
// centred crop. Ports: clk, reset (async low), in_* stream + zoom_level,
// out_* stream with sof/eol/eof, busy. ZOOM_PAN_EN adds pan_x/pan_y.
module zoom_stream
    import zoom_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CHANNELS      = 1,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int MAX_ZOOM_LOG2 = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_W*CHANNELS-1:0]         in_data,
    input  logic                               in_valid,
    input  logic                               in_sof,
    output logic                               in_ready,
    input  logic [$clog2(MAX_ZOOM_LOG2+1)-1:0] zoom_level,
`ifdef ZOOM_PAN_EN
    input  logic signed [$clog2(IMG_WIDTH):0]  pan_x,
    input  logic signed [$clog2(IMG_HEIGHT):0] pan_y,
`endif
    output logic [DATA_W*CHANNELS-1:0]         out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_sof,
    output logic                               out_eol,
    output logic                               out_eof,
    output logic                               busy
);

    localparam int PW   = DATA_W * CHANNELS;
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT);

    state_t        r_state;
    state_t        w_next;

    logic [AW-1:0] r_wr_addr;
    zlvl_t         r_lvl;
    logic [XW-1:0] r_x0;
    logic [YW-1:0] r_y0;

    logic [XW-1:0] r_rx;
    logic [YW-1:0] r_ry;
    logic          r_rd_done;
    logic          r_rd_vld;
    logic [2:0]    r_rd_flag;

    logic [PW-1:0] r_q_data [2];
    logic [2:0]    r_q_flag [2];
    logic          r_head;
    logic [1:0]    r_cnt;

    logic          w_in_hs;
    logic          w_sof_hs;
    logic          w_last_wr;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    zlvl_t         w_lvl_sat;
    logic [XW-1:0] w_x0;
    logic [YW-1:0] w_y0;

    logic          w_pop;
    logic          w_eof_pop;
    logic [2:0]    w_occ;
    logic          w_issue;
    logic          w_rx_last;
    logic          w_ry_last;
    logic [XW-1:0] w_sx;
    logic [YW-1:0] w_sy;
    logic [AW-1:0] w_raddr;
    logic [PW-1:0] w_ram_q;
    logic          w_wsel;

    // ---------------- input side ----------------
    assign w_in_hs   = in_valid && in_ready;
    assign w_sof_hs  = w_in_hs && in_sof;
    assign w_last_wr = (r_state == WRITE) && w_in_hs && !in_sof
                       && (r_wr_addr == AW'(NPIX - 1));
    // IDLE beats without sof are dropped; sof always lands at address 0.
    assign w_we      = w_in_hs && ((r_state == WRITE) || in_sof);
    assign w_waddr   = in_sof ? '0 : r_wr_addr;

    always_comb begin
        w_lvl_sat = zlvl_t'(zoom_level);
        if (int'(zoom_level) > MAX_ZOOM_LOG2)
            w_lvl_sat = zlvl_t'(MAX_ZOOM_LOG2);
    end

    always_comb begin
`ifdef ZOOM_PAN_EN
        w_x0 = XW'(crop_clamp(
                   crop_origin(IMG_WIDTH, int'(w_lvl_sat)) + int'(pan_x),
                   IMG_WIDTH, int'(w_lvl_sat)));
        w_y0 = YW'(crop_clamp(
                   crop_origin(IMG_HEIGHT, int'(w_lvl_sat)) + int'(pan_y),
                   IMG_HEIGHT, int'(w_lvl_sat)));
`else
        w_x0 = XW'(crop_origin(IMG_WIDTH, int'(w_lvl_sat)));
        w_y0 = YW'(crop_origin(IMG_HEIGHT, int'(w_lvl_sat)));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_addr <= '0;
            r_lvl     <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
        end else begin
            if (w_sof_hs) begin
                r_wr_addr <= AW'(1);
                r_lvl     <= w_lvl_sat;
                r_x0      <= w_x0;
                r_y0      <= w_y0;
            end else if (w_in_hs && (r_state == WRITE)) begin
                r_wr_addr <= w_last_wr ? '0 : r_wr_addr + AW'(1);
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_sof_hs)  w_next = WRITE;
            WRITE:   if (w_last_wr) w_next = READ;
            READ:    if (w_eof_pop) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state != READ);
        busy     = (r_state != IDLE);
    end

    // ---------------- read address generator ----------------
    assign w_pop     = out_valid && out_ready;
    assign w_eof_pop = w_pop && r_q_flag[r_head][0];

    // Entries held plus the read in flight, minus what leaves this cycle,
    // must leave a free slot for the read we are about to issue.
    assign w_occ   = {1'b0, r_cnt} + {2'b0, r_rd_vld} - {2'b0, w_pop};
    assign w_issue = (r_state == READ) && !r_rd_done && (w_occ < 3'd2);

    assign w_rx_last = (r_rx == XW'(IMG_WIDTH - 1));
    assign w_ry_last = (r_ry == YW'(IMG_HEIGHT - 1));
    assign w_sx      = r_x0 + (r_rx >> r_lvl);
    assign w_sy      = r_y0 + (r_ry >> r_lvl);
    assign w_raddr   = AW'(w_sy) * AW'(IMG_WIDTH) + AW'(w_sx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx      <= '0;
            r_ry      <= '0;
            r_rd_done <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_flag <= '0;
        end else if (r_state != READ) begin
            r_rx      <= '0;
            r_ry      <= '0;
            r_rd_done <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_flag <= {(r_rx == '0) && (r_ry == '0),
                              w_rx_last,
                              w_rx_last && w_ry_last};
                if (w_rx_last) begin
                    r_rx <= '0;
                    r_ry <= r_ry + YW'(1);
                    if (w_ry_last)
                        r_rd_done <= 1'b1;
                end else begin
                    r_rx <= r_rx + XW'(1);
                end
            end
        end
    end

    zoom_frame_ram #(
        .WIDTH (PW),
        .DEPTH (NPIX)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (in_data),
        .i_re    (w_issue),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    // ---------------- 2-entry skid buffer ----------------
    assign w_wsel = r_head ^ r_cnt[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= 1'b0;
            r_cnt  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_q_data[i] <= '0;
                r_q_flag[i] <= '0;
            end
        end else begin
            if (r_rd_vld) begin
                r_q_data[w_wsel] <= w_ram_q;
                r_q_flag[w_wsel] <= r_rd_flag;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_cnt <= r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
        end
    end

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_q_data[r_head];
    assign out_sof   = out_valid && r_q_flag[r_head][2];
    assign out_eol   = out_valid && r_q_flag[r_head][1];
    assign out_eof   = out_valid && r_q_flag[r_head][0];

endmodule
